// File: rtl/sb_io_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sb_io_pkg
// Purpose  : Mode encodings shared by the sb_io pad-cell model.
//            Output modes are PIN_TYPE[5:2]; input modes are PIN_TYPE[1:0].
// Revision : 1.0  initial release
// ============================================================================
package sb_io_pkg;

   // Output modes (PIN_TYPE[5:2])
   localparam logic [3:0] PIN_NO_OUTPUT                           = 4'b0000;
   localparam logic [3:0] PIN_OUTPUT                              = 4'b0110;
   localparam logic [3:0] PIN_OUTPUT_REGISTERED                   = 4'b0101;
   localparam logic [3:0] PIN_OUTPUT_TRISTATE                     = 4'b1010;
   localparam logic [3:0] PIN_OUTPUT_ENABLE_REGISTERED            = 4'b1001;
   localparam logic [3:0] PIN_OUTPUT_REGISTERED_ENABLE_REGISTERED = 4'b1101;
   localparam logic [3:0] PIN_OUTPUT_DDR                          = 4'b0100;
   localparam logic [3:0] PIN_OUTPUT_DDR_ENABLE_REGISTERED        = 4'b1100;

   // Input modes (PIN_TYPE[1:0])
   localparam logic [1:0] PIN_INPUT                  = 2'b01;
   localparam logic [1:0] PIN_INPUT_REGISTERED       = 2'b00;
   localparam logic [1:0] PIN_INPUT_LATCH            = 2'b11;
   localparam logic [1:0] PIN_INPUT_REGISTERED_LATCH = 2'b10;

   function automatic logic [3:0] out_mode_of(input logic [5:0] pin_type);
      return pin_type[5:2];
   endfunction

   function automatic logic [1:0] in_mode_of(input logic [5:0] pin_type);
      return pin_type[1:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/sb_io_if.sv
`default_nettype none
// ============================================================================
// Module   : sb_io_if
// Purpose  : Core-side signal bundle of one sb_io pad cell.
//            master : core logic (drives data/enable/control, reads inputs)
//            slave  : pad cell   (reads data/enable/control, drives inputs)
// Signals  : CLOCK_ENABLE, LATCH_INPUT_VALUE, OUTPUT_ENABLE, D_OUT_0, D_OUT_1
//            (core -> pad), D_IN_0, D_IN_1 (pad -> core)
// Revision : 1.0  initial release
// ============================================================================
interface sb_io_if;
   logic CLOCK_ENABLE;
   logic LATCH_INPUT_VALUE;
   logic OUTPUT_ENABLE;
   logic D_OUT_0;
   logic D_OUT_1;
   logic D_IN_0;
   logic D_IN_1;

   modport master (
      output CLOCK_ENABLE, LATCH_INPUT_VALUE, OUTPUT_ENABLE, D_OUT_0, D_OUT_1,
      input  D_IN_0, D_IN_1
   );

   modport slave (
      input  CLOCK_ENABLE, LATCH_INPUT_VALUE, OUTPUT_ENABLE, D_OUT_0, D_OUT_1,
      output D_IN_0, D_IN_1
   );
endinterface
`default_nettype wire

// File: rtl/sb_io_out_path.sv
`default_nettype none
// ============================================================================
// Module   : sb_io_out_path
// Purpose  : Output side of the sb_io pad cell: output-data and output-enable
//            registers, optional DDR register/mux, and the mode decode that
//            produces the pad driver enable and value.
// Ports    : clk, rst        clock / synchronous active-high reset
//            ce              register clock enable
//            oe, d0, d1      core output enable and data (d1 = DDR low phase)
//            pad_oe, pad_do  tristate driver enable and value for the pad
// Config   : `define SB_IO_DDR_EN enables DDR output modes 0100 / 1100.
// Revision : 1.0  initial release
// ============================================================================
module sb_io_out_path
   import sb_io_pkg::*;
#(
   parameter logic [3:0] OUT_MODE = PIN_NO_OUTPUT
) (
   input  wire  clk,
   input  wire  rst,
   input  wire  ce,
   input  wire  oe,
   input  wire  d0,
   input  wire  d1,
   output logic pad_oe,
   output logic pad_do
);

   logic out_q, out_d;
   logic oe_q,  oe_d;

   always_comb begin
      out_d = out_q;
      oe_d  = oe_q;
      if (ce) begin
         out_d = d0;
         oe_d  = oe;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q <= 1'b0;
         oe_q  <= 1'b0;
      end else begin
         out_q <= out_d;
         oe_q  <= oe_d;
      end
   end

`ifdef SB_IO_DDR_EN
   logic out1_q, out1_d;
   logic ddr_bit;

   always_comb begin
      out1_d = out1_q;
      if (ce) out1_d = d1;
   end

   always_ff @(posedge clk) begin
      if (rst) out1_q <= 1'b0;
      else     out1_q <= out1_d;
   end

   // The clock itself selects the phase: rising-edge data while high,
   // falling-edge data while low.
   assign ddr_bit = clk ? out_q : out1_q;
`else
   logic unused_d1;
   assign unused_d1 = d1;
`endif

   always_comb begin
      pad_oe = 1'b0;
      pad_do = 1'b0;
      case (OUT_MODE)
         PIN_OUTPUT: begin
            pad_oe = 1'b1;
            pad_do = d0;
         end
         PIN_OUTPUT_REGISTERED: begin
            pad_oe = 1'b1;
            pad_do = out_q;
         end
         PIN_OUTPUT_TRISTATE: begin
            pad_oe = oe;
            pad_do = d0;
         end
         PIN_OUTPUT_ENABLE_REGISTERED: begin
            pad_oe = oe_q;
            pad_do = d0;
         end
         PIN_OUTPUT_REGISTERED_ENABLE_REGISTERED: begin
            pad_oe = oe_q;
            pad_do = out_q;
         end
`ifdef SB_IO_DDR_EN
         PIN_OUTPUT_DDR: begin
            pad_oe = 1'b1;
            pad_do = ddr_bit;
         end
         PIN_OUTPUT_DDR_ENABLE_REGISTERED: begin
            pad_oe = oe_q;
            pad_do = ddr_bit;
         end
`endif
         // No-output, reserved codes and (without DDR) the DDR codes float.
         default: begin
            pad_oe = 1'b0;
            pad_do = 1'b0;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/sb_io.sv
`default_nettype none
// ============================================================================
// Module   : sb_io
// Purpose  : Behavioural model of one bidirectional FPGA pad cell
//            (iCE40 SB_IO style) with optional registering on the output,
//            output-enable and input paths.
// Ports    : clk          single clock for every register in the cell
//            rst          synchronous active-high reset
//            io (slave)   core-side bundle: CLOCK_ENABLE, LATCH_INPUT_VALUE,
//                         OUTPUT_ENABLE, D_OUT_0, D_OUT_1, D_IN_0, D_IN_1
//            PACKAGE_PIN  physical pad
// Params   : PIN_TYPE  [5:2] output mode, [1:0] input mode
//            PULLUP    1 adds a weak pull-up on the pad
// Config   : `define SB_IO_DDR_EN enables DDR output modes and the
//            falling-edge input capture on D_IN_1.
// Revision : 1.0  initial release
// ============================================================================
module sb_io
   import sb_io_pkg::*;
#(
   parameter logic [5:0] PIN_TYPE = 6'b000001,
   parameter logic       PULLUP   = 1'b0
) (
   input  wire     clk,
   input  wire     rst,
   sb_io_if.slave  io,
   inout  wire     PACKAGE_PIN
);

   localparam logic [3:0] OUT_MODE = out_mode_of(PIN_TYPE);
   localparam logic [1:0] IN_MODE  = in_mode_of(PIN_TYPE);

   // ---------------------------------------------------------------- output
   logic pad_oe;
   logic pad_do;

   sb_io_out_path #(
      .OUT_MODE (OUT_MODE)
   ) u_out_path (
      .clk    (clk),
      .rst    (rst),
      .ce     (io.CLOCK_ENABLE),
      .oe     (io.OUTPUT_ENABLE),
      .d0     (io.D_OUT_0),
      .d1     (io.D_OUT_1),
      .pad_oe (pad_oe),
      .pad_do (pad_do)
   );

   assign PACKAGE_PIN = pad_oe ? pad_do : 1'bz;

   generate
      if (PULLUP) begin : g_pullup
         pullup u_pullup (PACKAGE_PIN);
      end
   endgenerate

   // ----------------------------------------------------------------- input
   // Always the resolved pad value, so a driven pad loops back its output.
   logic pad_in;
   assign pad_in = PACKAGE_PIN;

   logic in_q,   in_d;
   logic hold_q, hold_d;
   logic din0;

   always_comb begin
      in_d   = in_q;
      hold_d = hold_q;
      if (io.CLOCK_ENABLE) begin
         // The registered-latch mode freezes the input register while the
         // latch control is high; plain registered mode ignores it.
         if (!((IN_MODE == PIN_INPUT_REGISTERED_LATCH) && io.LATCH_INPUT_VALUE))
            in_d = pad_in;
         // Hold value tracks the pad until the latch control freezes it.
         if (!io.LATCH_INPUT_VALUE)
            hold_d = pad_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         in_q   <= 1'b0;
         hold_q <= 1'b0;
      end else begin
         in_q   <= in_d;
         hold_q <= hold_d;
      end
   end

   always_comb begin
      din0 = pad_in;
      case (IN_MODE)
         PIN_INPUT:                  din0 = pad_in;
         PIN_INPUT_REGISTERED:       din0 = in_q;
         PIN_INPUT_REGISTERED_LATCH: din0 = in_q;
         PIN_INPUT_LATCH:            din0 = io.LATCH_INPUT_VALUE ? hold_q : pad_in;
         default:                    din0 = pad_in;
      endcase
   end

   assign io.D_IN_0 = din0;

`ifdef SB_IO_DDR_EN
   // Falling-edge capture. Reset is taken on the rising edge and applied to
   // this register on the following falling edge.
   logic ddr_clr_q;
   logic in1_q, in1_d;

   always_comb begin
      in1_d = in1_q;
      if (io.CLOCK_ENABLE) in1_d = pad_in;
   end

   always_ff @(posedge clk) begin
      ddr_clr_q <= rst;
   end

   always_ff @(negedge clk) begin
      if (ddr_clr_q) in1_q <= 1'b0;
      else           in1_q <= in1_d;
   end

   assign io.D_IN_1 = in1_q;
`else
   assign io.D_IN_1 = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sb_io.sv
`default_nettype none
// ============================================================================
// Module   : tb_sb_io
// Purpose  : Self-checking bench for sb_io. Several cells with different
//            PIN_TYPE / PULLUP settings share one set of core stimulus;
//            directed steps cover the documented scenarios, then random
//            stimulus is compared against a cycle-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_sb_io;

   logic clk;
   logic rst, ce, liv, oe, d0, d1, ext_on, ext_val;
   int   checks = 0;
   int   errors = 0;

   // a: tristate, comb in           b: same with pull-up
   // c: reg out + reg OE, reg in    d: reg out, reg in
   // e: tristate, latch in          g: tristate, registered-latch in
   // h: reg OE, comb in (pull-up)   i: comb always-driven output
   // f: DDR always-driven, reg in (pull-up)
   sb_io_if if_a (); sb_io_if if_b (); sb_io_if if_c (); sb_io_if if_d ();
   sb_io_if if_e (); sb_io_if if_g (); sb_io_if if_h (); sb_io_if if_i ();
   sb_io_if if_f ();
   wire pad_a, pad_b, pad_c, pad_d, pad_e, pad_g, pad_h, pad_i, pad_f;

   assign {if_a.CLOCK_ENABLE, if_a.LATCH_INPUT_VALUE, if_a.OUTPUT_ENABLE, if_a.D_OUT_0, if_a.D_OUT_1} = {ce, liv, oe, d0, d1};
   assign {if_b.CLOCK_ENABLE, if_b.LATCH_INPUT_VALUE, if_b.OUTPUT_ENABLE, if_b.D_OUT_0, if_b.D_OUT_1} = {ce, liv, oe, d0, d1};
   assign {if_c.CLOCK_ENABLE, if_c.LATCH_INPUT_VALUE, if_c.OUTPUT_ENABLE, if_c.D_OUT_0, if_c.D_OUT_1} = {ce, liv, oe, d0, d1};
   assign {if_d.CLOCK_ENABLE, if_d.LATCH_INPUT_VALUE, if_d.OUTPUT_ENABLE, if_d.D_OUT_0, if_d.D_OUT_1} = {ce, liv, oe, d0, d1};
   assign {if_e.CLOCK_ENABLE, if_e.LATCH_INPUT_VALUE, if_e.OUTPUT_ENABLE, if_e.D_OUT_0, if_e.D_OUT_1} = {ce, liv, oe, d0, d1};
   assign {if_g.CLOCK_ENABLE, if_g.LATCH_INPUT_VALUE, if_g.OUTPUT_ENABLE, if_g.D_OUT_0, if_g.D_OUT_1} = {ce, liv, oe, d0, d1};
   assign {if_h.CLOCK_ENABLE, if_h.LATCH_INPUT_VALUE, if_h.OUTPUT_ENABLE, if_h.D_OUT_0, if_h.D_OUT_1} = {ce, liv, oe, d0, d1};
   assign {if_i.CLOCK_ENABLE, if_i.LATCH_INPUT_VALUE, if_i.OUTPUT_ENABLE, if_i.D_OUT_0, if_i.D_OUT_1} = {ce, liv, oe, d0, d1};
   assign {if_f.CLOCK_ENABLE, if_f.LATCH_INPUT_VALUE, if_f.OUTPUT_ENABLE, if_f.D_OUT_0, if_f.D_OUT_1} = {ce, liv, oe, d0, d1};

   sb_io #(.PIN_TYPE(6'b101001), .PULLUP(1'b0)) u_a (.clk(clk), .rst(rst), .io(if_a), .PACKAGE_PIN(pad_a));
   sb_io #(.PIN_TYPE(6'b101001), .PULLUP(1'b1)) u_b (.clk(clk), .rst(rst), .io(if_b), .PACKAGE_PIN(pad_b));
   sb_io #(.PIN_TYPE(6'b110100), .PULLUP(1'b1)) u_c (.clk(clk), .rst(rst), .io(if_c), .PACKAGE_PIN(pad_c));
   sb_io #(.PIN_TYPE(6'b010100), .PULLUP(1'b0)) u_d (.clk(clk), .rst(rst), .io(if_d), .PACKAGE_PIN(pad_d));
   sb_io #(.PIN_TYPE(6'b101011), .PULLUP(1'b0)) u_e (.clk(clk), .rst(rst), .io(if_e), .PACKAGE_PIN(pad_e));
   sb_io #(.PIN_TYPE(6'b101010), .PULLUP(1'b0)) u_g (.clk(clk), .rst(rst), .io(if_g), .PACKAGE_PIN(pad_g));
   sb_io #(.PIN_TYPE(6'b100101), .PULLUP(1'b1)) u_h (.clk(clk), .rst(rst), .io(if_h), .PACKAGE_PIN(pad_h));
   sb_io #(.PIN_TYPE(6'b011001), .PULLUP(1'b0)) u_i (.clk(clk), .rst(rst), .io(if_i), .PACKAGE_PIN(pad_i));
   sb_io #(.PIN_TYPE(6'b010000), .PULLUP(1'b1)) u_f (.clk(clk), .rst(rst), .io(if_f), .PACKAGE_PIN(pad_f));

   // External drivers only act while the cell's own tristate enable is off.
   assign pad_a = (ext_on && !oe) ? ext_val : 1'bz;
   assign pad_e = (ext_on && !oe) ? ext_val : 1'bz;
   assign pad_g = (ext_on && !oe) ? ext_val : 1'bz;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish, expected finish before 100000");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Reference model state (the registered quantities the rules imply)
   logic m_out_c, m_oe_c, m_in_c, m_out_d, m_in_d, m_hold_e, m_in_g, m_oe_h, m_in_f;
   logic pa, pb, pc, ph;

   initial begin
      rst = 1'b1; ce = 1'b1; liv = 1'b0; oe = 1'b0; d0 = 1'b0; d1 = 1'b0;
      ext_on = 1'b0; ext_val = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      // ---------------- reset state
      chk("rst_c_din", if_c.D_IN_0, 1'b0);
      chk("rst_c_pad_released", pad_c, 1'b1);
      chk("rst_d_pad", pad_d, 1'b0);
      chk("rst_d_din", if_d.D_IN_0, 1'b0);
      chk("rst_g_din", if_g.D_IN_0, 1'b0);
      chk("rst_f_din1", if_f.D_IN_1, 1'b0);
      rst = 1'b0;

      // ---------------- combinational tristate + loopback, no clock edge
      oe = 1'b1; d0 = 1'b1; #1;
      chk("a_drive_pad", pad_a, 1'b1);
      chk("a_loopback", if_a.D_IN_0, 1'b1);
      oe = 1'b0; ext_on = 1'b1; ext_val = 1'b0; #1;
      chk("a_ext_pad", pad_a, 1'b0);
      chk("a_ext_din", if_a.D_IN_0, 1'b0);
      chk("b_pullup_din", if_b.D_IN_0, 1'b1);

      // ---------------- registered output + registered enable
      ext_on = 1'b0; d0 = 1'b0; oe = 1'b1; #1;
      chk("c_oe_latency", pad_c, 1'b1);
      @(posedge clk); #1;
      chk("c_drive0", pad_c, 1'b0);
      d0 = 1'b1;
      @(posedge clk); #1;
      chk("c_drive1", pad_c, 1'b1);
      chk("c_din_lag", if_c.D_IN_0, 1'b0);
      @(posedge clk); #1;
      chk("c_din", if_c.D_IN_0, 1'b1);
      d0 = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("c_rst_release", pad_c, 1'b1);
      chk("c_rst_din", if_c.D_IN_0, 1'b0);

      // ---------------- clock enable holds registers
      ce = 1'b0; d0 = 1'b1;
      @(posedge clk); #1;
      chk("d_ce_hold", pad_d, 1'b0);
      ce = 1'b1;
      @(posedge clk); #1;
      chk("d_ce_update", pad_d, 1'b1);
      chk("d_din_lag", if_d.D_IN_0, 1'b0);

      // ---------------- latch input modes
      oe = 1'b0; ext_on = 1'b1; ext_val = 1'b1; liv = 1'b0;
      @(posedge clk); #1;
      chk("e_follow", if_e.D_IN_0, 1'b1);
      chk("g_sample", if_g.D_IN_0, 1'b1);
      liv = 1'b1; ext_val = 1'b0; #1;
      chk("e_hold", if_e.D_IN_0, 1'b1);
      chk("a_follow", if_a.D_IN_0, 1'b0);
      @(posedge clk); #1;
      chk("e_hold_edge", if_e.D_IN_0, 1'b1);
      chk("g_hold", if_g.D_IN_0, 1'b1);
      liv = 1'b0; #1;
      chk("e_release", if_e.D_IN_0, 1'b0);
      @(posedge clk); #1;
      chk("g_release", if_g.D_IN_0, 1'b0);

      // ---------------- DDR output / falling-edge input
      ext_on = 1'b0; d0 = 1'b1; d1 = 1'b0;
      @(posedge clk); #2;
`ifdef SB_IO_DDR_EN
      chk("f_ddr_high", pad_f, 1'b1);
      @(negedge clk); #2;
      chk("f_ddr_low", pad_f, 1'b0);
      d0 = 1'b1; d1 = 1'b1;
      @(posedge clk); @(negedge clk); #1;
      chk("f_din1_one", if_f.D_IN_1, 1'b1);
      d0 = 1'b0; d1 = 1'b0;
      @(posedge clk); @(negedge clk); #1;
      chk("f_din1_zero", if_f.D_IN_1, 1'b0);
`else
      chk("f_no_ddr_pad", pad_f, 1'b1);
      chk("f_no_ddr_din1", if_f.D_IN_1, 1'b0);
`endif

      // ---------------- random stimulus against the reference model
      rst = 1'b1; ext_on = 1'b1; liv = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      {m_out_c, m_oe_c, m_in_c, m_out_d, m_in_d, m_hold_e, m_in_g, m_oe_h, m_in_f} = '0;

      for (int it = 0; it < 64; it++) begin
         rst     = ($urandom_range(0, 15) == 0);
         ce      = ($urandom_range(0, 3) != 0);
         liv     = 1'($urandom_range(0, 1));
         oe      = 1'($urandom_range(0, 1));
         d0      = 1'($urandom_range(0, 1));
         d1      = 1'($urandom_range(0, 1));
         ext_val = 1'($urandom_range(0, 1));
         #1;
         // Resolved pad values: driven value when enabled, else the
         // external driver or the pull-up.
         pa = oe ? d0 : ext_val;
         pb = oe ? d0 : 1'b1;
         pc = m_oe_c ? m_out_c : 1'b1;
         ph = m_oe_h ? d0 : 1'b1;
         chk("rnd_a_pad", pad_a, pa);
         chk("rnd_a_din", if_a.D_IN_0, pa);
         chk("rnd_b_din", if_b.D_IN_0, pb);
         chk("rnd_c_pad", pad_c, pc);
         chk("rnd_c_din", if_c.D_IN_0, m_in_c);
         chk("rnd_d_pad", pad_d, m_out_d);
         chk("rnd_d_din", if_d.D_IN_0, m_in_d);
         chk("rnd_e_din", if_e.D_IN_0, liv ? m_hold_e : pa);
         chk("rnd_g_din", if_g.D_IN_0, m_in_g);
         chk("rnd_h_pad", pad_h, ph);
         chk("rnd_h_din", if_h.D_IN_0, ph);
         chk("rnd_i_pad", pad_i, d0);
`ifndef SB_IO_DDR_EN
         chk("rnd_f_din", if_f.D_IN_0, m_in_f);
         chk("rnd_f_din1", if_f.D_IN_1, 1'b0);
`endif
         // What the next rising edge stores
         if (rst) begin
            {m_out_c, m_oe_c, m_in_c, m_out_d, m_in_d, m_hold_e, m_in_g, m_oe_h, m_in_f} = '0;
         end else if (ce) begin
            m_out_c = d0;
            m_oe_c  = oe;
            m_in_c  = pc;
            m_in_d  = m_out_d;
            m_out_d = d0;
            m_oe_h  = oe;
            m_in_f  = 1'b1;
            if (!liv) begin
               m_hold_e = pa;
               m_in_g   = pa;
            end
         end
         @(posedge clk); #1;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
